// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Holds the FSM state enum, the sizing constants and a one-hot helper.
package arb_pkg;

    localparam int N       = 8;
    localparam int IDXW    = 3;
    localparam int TIMEOUT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot_of(input logic [IDXW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: finds the first set request
// searching i_ptr+1, i_ptr+2, ... modulo N, so i_ptr itself is checked last.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic [N-1:0]    o_pick,
    output logic [IDXW-1:0] o_idx,
    output logic            o_any
);

    logic [IDXW-1:0] w_cand;

    // NOTE: combinational logic uses blocking assignments and gives every
    // output a default first, so no latch is inferred.
    always_comb begin
        o_any  = 1'b0;
        o_idx  = '0;
        w_cand = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = i_ptr + IDXW'(k);
            if (!o_any && i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
        o_pick = onehot_of(o_idx) & {N{o_any}};
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered one-hot grant (feeds an 8-to-3 encoder).
// Optional forced release after TIMEOUT hold cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8
    import arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic         timeout
);

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_gnt, w_gnt_nxt;
    logic [IDXW-1:0] r_ptr, w_ptr_nxt;
    logic [IDXW-1:0] r_owner, w_owner_nxt;
    logic            r_gnt_valid;

    logic [N-1:0]    w_pick_req, w_pick;
    logic [IDXW-1:0] w_pick_ptr, w_pick_idx;
    logic            w_any;
    logic            w_expire;

    // While granted, the owner is excluded and the search starts after it.
    assign w_pick_req = (r_state == GRANT) ? (req & ~r_gnt) : req;
    assign w_pick_ptr = (r_state == GRANT) ? r_owner : r_ptr;

    rr_pick u_pick (
        .i_req  (w_pick_req),
        .i_ptr  (w_pick_ptr),
        .o_pick (w_pick),
        .o_idx  (w_pick_idx),
        .o_any  (w_any)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_timeout;

    assign w_expire = (r_state == GRANT) && (r_cnt == CW'(TIMEOUT - 1));
    assign timeout  = r_timeout;

    // Counter runs only while the same owner keeps the grant.
    assign w_cnt_nxt = ((r_state == GRANT) && (w_state_nxt == GRANT) && (w_gnt_nxt == r_gnt))
                       ? r_cnt + 1'b1 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_expire && !ack && req[r_owner];
        end
    end
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                w_gnt_nxt = '0;
                if (w_any) begin
                    w_gnt_nxt   = w_pick;
                    w_owner_nxt = w_pick_idx;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (ack || (req[r_owner] && w_expire)) begin
                    w_ptr_nxt = r_owner;
                    if (w_any) begin
                        w_gnt_nxt   = w_pick;
                        w_owner_nxt = w_pick_idx;
                    end else begin
                        w_gnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end
                end else if (!req[r_owner]) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= IDXW'(N - 1);
            r_owner     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= |w_gnt_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;

endmodule
